// File: rtl/sd_spi_reader.sv
// SPI mode-0 read master: sends a read opcode, polls MISO for a start token,
// then captures a 16-bit word and reports it with a valid or timeout pulse.
module sd_spi_reader #(
  parameter int         CLK_DIV       = 4,
  parameter logic [7:0] READ_CMD      = 8'h11,
  parameter logic [7:0] TOKEN         = 8'hFE,
  parameter int         TIMEOUT_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] data_out,
  output logic        valid,
  output logic        error,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = (TIMEOUT_BYTES > 1) ? $clog2(TIMEOUT_BYTES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WAIT, S_DATA, S_FINISH
  } state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_div;
  logic            r_sclk;
  logic [7:0]      r_tx;
  logic [15:0]     r_rx;
  logic [3:0]      r_bit;
  logic [PW-1:0]   r_poll;
  logic            r_ok;
  logic            r_cs, r_busy, r_valid, r_error;
  logic [15:0]     r_data;

  logic w_tc, w_shift, w_rise, w_fall, w_last_bit, w_grp_done;
  logic w_tok, w_poll_out, w_accept, w_done;

  assign w_tc       = (r_div == DW'(HALF - 1));
  assign w_shift    = (r_state == S_CMD) || (r_state == S_WAIT) || (r_state == S_DATA);
  assign w_rise     = w_shift && w_tc && !r_sclk;
  assign w_fall     = w_shift && w_tc &&  r_sclk;
  assign w_last_bit = (r_state == S_DATA) ? (r_bit == 4'd15) : (r_bit == 4'd7);
  // Groups close on the falling edge so every state change happens with sclk low.
  assign w_grp_done = w_fall && w_last_bit;
  assign w_tok      = (r_rx[7:0] == TOKEN);
  assign w_poll_out = (r_poll == PW'(TIMEOUT_BYTES - 1));
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_done     = (r_state == S_FINISH) && w_tc;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)      w_next = S_SETUP;
      S_SETUP:  if (w_tc)       w_next = S_CMD;
      S_CMD:    if (w_grp_done) w_next = S_WAIT;
      S_WAIT:   if (w_grp_done) begin
                  if (w_tok)           w_next = S_DATA;
                  else if (w_poll_out) w_next = S_FINISH;
                end
      S_DATA:   if (w_grp_done) w_next = S_FINISH;
      S_FINISH: if (w_tc)       w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_tx    <= 8'hFF;
      r_rx    <= '0;
      r_bit   <= '0;
      r_poll  <= '0;
      r_ok    <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;

      if (r_state == S_IDLE || w_tc) r_div <= '0;
      else                           r_div <= r_div + 1'b1;

      if (w_shift && w_tc) r_sclk <= ~r_sclk;

      // Ones shift in behind the opcode so MOSI rests high while polling/reading.
      if (w_accept)    r_tx <= READ_CMD;
      else if (w_fall) r_tx <= {r_tx[6:0], 1'b1};

      if (w_rise) r_rx <= {r_rx[14:0], miso};

      if (w_accept)    r_bit <= '0;
      else if (w_fall) r_bit <= w_last_bit ? 4'd0 : r_bit + 4'd1;

      if (w_accept)
        r_poll <= '0;
      else if (r_state == S_WAIT && w_grp_done && !w_tok)
        r_poll <= r_poll + 1'b1;

      if (w_accept)
        r_ok <= 1'b0;
      else if (r_state == S_DATA && w_grp_done)
        r_ok <= 1'b1;

      if (w_accept) begin
        r_cs   <= 1'b0;
        r_busy <= 1'b1;
      end else if (w_done) begin
        r_cs    <= 1'b1;
        r_busy  <= 1'b0;
        r_valid <= r_ok;
        r_error <= ~r_ok;
        if (r_ok) r_data <= r_rx;
      end
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign error    = r_error;
  assign busy     = r_busy;
  assign sclk     = r_sclk;
  assign mosi     = r_tx[7];
  assign cs       = r_cs;

endmodule

// File: tb/tb_sd_spi_reader.sv
// Directed bench for sd_spi_reader: a MISO stream model per transaction,
// edge/pulse monitors, and immediate-assertion checks against hand values.
module tb_sd_spi_reader;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, miso;
  logic [15:0] data_out;
  logic        valid, error, busy, sclk, mosi, cs;

  always #5 clk = ~clk;

  sd_spi_reader #(.CLK_DIV(4), .READ_CMD(8'h11), .TOKEN(8'hFE), .TIMEOUT_BYTES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .data_out(data_out), .valid(valid),
    .error(error), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
  );

  int total = 0, bad = 0;

  // Bits the device returns after the opcode, MSB first; ones past the end.
  logic [127:0] stream = '1;
  int nrise = 0, base = 0, idx;
  logic [7:0] op = 8'h00;

  always @(posedge sclk) begin
    if (nrise - base < 8) op = {op[6:0], mosi};
    nrise++;
  end

  always @(negedge cs) base = nrise;

  always_comb begin
    idx  = nrise - base - 8;
    miso = 1'b1;
    if (idx >= 0 && idx < 128) miso = stream[127 - idx];
  end

  int n_busy = 0, n_valid = 0, n_err = 0, n_vcs = 0, n_fall = 0, n_both = 0;
  logic cs_q = 1'b1, busy_q = 1'b0;

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (valid) begin
      n_valid++;
      if (cs && !cs_q) n_vcs++;
    end
    if (error) n_err++;
    if (valid && error) n_both++;
    if (busy_q && !busy) n_fall++;
    cs_q   = cs;
    busy_q = busy;
  end

  int s_busy, s_valid, s_err, s_vcs, s_fall;
  int d_busy, d_valid, d_err, d_vcs, d_fall, d_rise;
  logic tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_busy = n_busy; s_valid = n_valid; s_err = n_err; s_vcs = n_vcs; s_fall = n_fall;
  endtask

  task automatic diff();
    d_busy = n_busy - s_busy; d_valid = n_valid - s_valid; d_err = n_err - s_err;
    d_vcs = n_vcs - s_vcs; d_fall = n_fall - s_fall; d_rise = nrise - base;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_txn(input logic [127:0] s, input bit extra);
    stream = s;
    snap();
    pulse_start();
    if (extra) begin
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    tmo = busy;
    repeat (3) @(posedge clk);
    #1 diff();
  endtask

  initial begin
    // Reset held with start asserted
    rst = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h1);
    chk("rst_cs", 32'(cs), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_edges", 32'(nrise), 32'h0);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Token on first poll byte
    do_txn({8'hFE, 16'hA55A, {104{1'b1}}}, 1'b0);
    chk("t2_tmo", 32'(tmo), 32'h0);
    chk("t2_op", 32'(op), 32'h11);
    chk("t2_rises", 32'(d_rise), 32'd32);
    chk("t2_busy", 32'(d_busy), 32'd132);
    chk("t2_data", 32'(data_out), 32'hA55A);
    chk("t2_valid", 32'(d_valid), 32'd1);
    chk("t2_valid_cs", 32'(d_vcs), 32'd1);
    chk("t2_err", 32'(d_err), 32'd0);

    // Token on third poll byte
    do_txn({8'hFF, 8'hFF, 8'hFE, 16'h1234, {88{1'b1}}}, 1'b0);
    chk("t3_tmo", 32'(tmo), 32'h0);
    chk("t3_op", 32'(op), 32'h11);
    chk("t3_rises", 32'(d_rise), 32'd48);
    chk("t3_busy", 32'(d_busy), 32'd196);
    chk("t3_data", 32'(data_out), 32'h1234);
    chk("t3_valid", 32'(d_valid), 32'd1);
    chk("t3_err", 32'(d_err), 32'd0);

    // No token: timeout after 8 poll bytes
    do_txn({128{1'b1}}, 1'b0);
    chk("t4_tmo", 32'(tmo), 32'h0);
    chk("t4_rises", 32'(d_rise), 32'd72);
    chk("t4_busy", 32'(d_busy), 32'd292);
    chk("t4_err", 32'(d_err), 32'd1);
    chk("t4_valid", 32'(d_valid), 32'd0);
    chk("t4_data", 32'(data_out), 32'h1234);

    // Second start during an active transfer is ignored
    do_txn({8'hFE, 16'hC3C3, {104{1'b1}}}, 1'b1);
    chk("t5_tmo", 32'(tmo), 32'h0);
    chk("t5_rises", 32'(d_rise), 32'd32);
    chk("t5_busy", 32'(d_busy), 32'd132);
    chk("t5_busy_falls", 32'(d_fall), 32'd1);
    chk("t5_valid", 32'(d_valid), 32'd1);
    chk("t5_data", 32'(data_out), 32'hC3C3);

    // Reset in the middle of DATA
    stream = {8'hFE, 16'h0F0F, {104{1'b1}}};
    snap();
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (nrise - base >= 24) break;
      @(posedge clk); #1;
    end
    chk("t6_reach_data", 32'(nrise - base >= 24), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_cs", 32'(cs), 32'h1);
    chk("t6_sclk", 32'(sclk), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_mosi", 32'(mosi), 32'h1);
    chk("t6_data", 32'(data_out), 32'h0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 diff();
    chk("t6_no_valid", 32'(d_valid), 32'd0);
    chk("t6_no_err", 32'(d_err), 32'd0);

    do_txn({8'hFE, 16'hBEEF, {104{1'b1}}}, 1'b0);
    chk("t6b_tmo", 32'(tmo), 32'h0);
    chk("t6b_data", 32'(data_out), 32'hBEEF);
    chk("t6b_valid", 32'(d_valid), 32'd1);
    chk("t6b_busy", 32'(d_busy), 32'd132);

    chk("never_both", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_reader.md
Name: sd_spi_reader

Overview:
SPI mode-0 master that reads one 16-bit word from the SD/flash device. It is the read-side counterpart of sd_spi_writer on the same sclk/mosi/miso/cs bus. On start it drops cs and shifts out an 8-bit read opcode. It then polls MISO byte-by-byte for the start token, captures the next 16 bits and presents them with a one-cycle valid strobe. If no token arrives within a byte budget, it flags an error instead.

Parameters:
CLK_DIV, 4, clk cycles per sclk period; even, >= 2; sclk half-period = CLK_DIV/2 clk cycles (100 MHz clk -> 25 MHz sclk)
READ_CMD, 8'h11, opcode shifted out on MOSI, MSB first
TOKEN, 8'hFE, data start token expected on MISO
TIMEOUT_BYTES, 8, maximum token-poll bytes before error (>= 1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  request a read; sampled only in IDLE
data_out  output  16  last successfully read word
valid  output  1  one-cycle pulse: data_out updated
error  output  1  one-cycle pulse: token timeout
busy  output  1  high from cycle after accepted start until return to IDLE
sclk  output  1  SPI clock, idles low
mosi  output  1  SPI data out, idles high
miso  input  1  SPI data in
cs  output  1  chip select, active-low, idles high

Behaviour:
- Reset (rst=0 at clk edge): sclk=0, mosi=1, cs=1, busy=0, valid=0, error=0, data_out=16'h0000, state IDLE, all counters cleared. Reset takes priority over start and mid-transfer activity; cs returns high on the same edge.
- Divider: counter 0..CLK_DIV/2-1 runs only outside IDLE. At terminal count sclk toggles. A rising sclk edge samples miso into the shift register on that clk edge. A falling sclk edge advances mosi to the next bit.
- Bit order: MSB first for opcode, token and data.
- States:
  - IDLE: cs=1, sclk=0. start=1 -> SETUP; busy=1 next cycle.
  - SETUP: cs=0; mosi=READ_CMD[7]; wait one half-period -> CMD.
  - CMD: 8 sclk periods driving READ_CMD -> WAIT_TOKEN.
  - WAIT_TOKEN: mosi=1; collect byte-aligned 8-bit groups. Compare each completed byte with TOKEN.
    - Match -> DATA.
    - No match -> poll count +1. When count reaches TIMEOUT_BYTES -> FINISH with error flag set.
  - DATA: mosi=1; 16 sclk periods. After the 16th rising edge, latch the shift register -> FINISH with success flag.
  - FINISH: sclk held low one half-period, then cs=1 and busy=0. Pulse valid (success, data_out updated the same edge) or error (data_out unchanged) for exactly one cycle -> IDLE.
- Token detection is byte-aligned only; a token straddling byte boundaries is not recognised.
- Busy duration: N = 8 + 8*k (+16 on success), where k = polled bytes including the matching one. busy stays high for CLK_DIV*N + CLK_DIV clk cycles. Example: CLK_DIV=4, k=1 -> N=32 -> 132 cycles.
- start while busy: ignored, no queuing. start held high through IDLE re-entry starts a new transfer on the first IDLE cycle.
- valid and error are never high together. Neither is high outside the FINISH->IDLE edge.

Test Plan:
1. Hold rst=0 for 5 cycles, start=1 throughout -> sclk=0, mosi=1, cs=1, busy=0, valid=0, error=0, data_out=0000; no sclk edges.
2. Release reset; pulse start; MISO model returns FE on first poll byte, then 16'hA55A -> MOSI bits decode 8'h11; 32 sclk rising edges; busy high 132 cycles; data_out=A55A with a single valid pulse coincident with cs rising; error stays 0.
3. Model returns FF, FF, FE, then 16'h1234 -> 48 sclk edges; data_out=1234; one valid pulse; error=0.
4. Model returns FF forever, TIMEOUT_BYTES=8 -> 72 sclk edges; one error pulse; valid stays 0; data_out stays 1234 from the prior test.
5. Pulse start again 10 cycles into an active transfer -> exactly one transaction (sclk edge count unchanged); busy never deasserts early.
6. Drive rst=0 for one cycle midway through DATA -> next edge cs=1, sclk=0, busy=0, no valid/error pulse, data_out=0000. A subsequent start with FE+16'hBEEF gives data_out=BEEF.
